// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue command generator.
package pq_pkg;

    localparam int KW_DEF = 8;
    localparam int VW_DEF = 8;

    // Galois feedback taps for the 8-bit right-shifting key LFSR
    localparam logic [7:0] LFSR_MASK = 8'hB8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gen_state_t;

endpackage

// File: rtl/pq_lfsr.sv
// Seeded 8-bit Galois LFSR (right shift) that advances only when enabled.
// A synchronous reset reloads the seed; a zero seed would lock up, so it
// is replaced by 1.
module pq_lfsr
    import pq_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       advance,
    output logic [7:0] state
);

    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] state_reg;
    logic [7:0] state_next;

    // Shift right and fold the taps in when the dropped bit was 1
    always_comb begin
        state_next = state_reg;
        if (advance) begin
            state_next = {1'b0, state_reg[7:1]} ^ (state_reg[0] ? LFSR_MASK : 8'h00);
        end
    end

    // State register, reloaded with the seed on reset
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= SEED_EFF;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/pq_cmd_gen.sv
// Stimulus and self-check stage for the priority-queue core: each round
// fills the queue with LFSR keys, drains it, and checks that the keys come
// back in non-decreasing order with one result per remove.
module pq_cmd_gen
    import pq_pkg::*;
#(
    parameter int         KW     = KW_DEF,
    parameter int         VW     = VW_DEF,
    parameter logic [7:0] SEED   = 8'hA5,
    parameter int         N_FILL = 16,
    parameter int         ROUNDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cmd_ready,
    input  logic                         pq_full,
    input  logic                         pq_empty,
    input  logic                         rd_valid,
    input  logic [KW-1:0]                rd_key,
    output logic                         add,
    output logic                         remove,
    output logic [KW-1:0]                data1,
    output logic [VW-1:0]                data2,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(ROUNDS+1)-1:0]  round_cnt
);

    localparam int CW = $clog2(N_FILL + 1);
    localparam int RW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] N_FILL_C   = CW'(N_FILL);
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    gen_state_t    state_reg, state_next;
    logic [CW-1:0] add_cnt_reg, add_cnt_next;
    logic [CW-1:0] rm_cnt_reg, rm_cnt_next;
    logic [CW-1:0] rd_cnt_reg, rd_cnt_next;
    logic [KW-1:0] last_key_reg, last_key_next;
    logic [RW-1:0] round_cnt_reg, round_cnt_next;
    logic          err_reg, err_next;
    logic          lfsr_adv;
    logic [7:0]    lfsr_state;

    pq_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk    (clk),
        .srst   (rst),
        .advance(lfsr_adv),
        .state  (lfsr_state)
    );

    // Key is the LFSR state, zero-padded or truncated to KW
    genvar gi;
    for (gi = 0; gi < KW; gi++) begin : g_data1
        if (gi < 8) begin : g_bit
            assign data1[gi] = lfsr_state[gi];
        end else begin : g_pad
            assign data1[gi] = 1'b0;
        end
    end

    // Payload is the add index within the current round
    for (gi = 0; gi < VW; gi++) begin : g_data2
        if (gi < CW) begin : g_bit
            assign data2[gi] = add_cnt_reg[gi];
        end else begin : g_pad
            assign data2[gi] = 1'b0;
        end
    end

    // Next-state, request and checker logic
    always_comb begin
        state_next     = state_reg;
        add_cnt_next   = add_cnt_reg;
        rm_cnt_next    = rm_cnt_reg;
        rd_cnt_next    = rd_cnt_reg;
        last_key_next  = last_key_reg;
        round_cnt_next = round_cnt_reg;
        err_next       = err_reg;
        add            = 1'b0;
        remove         = 1'b0;
        lfsr_adv       = 1'b0;
        done           = 1'b0;

        // A result outside DRAIN can never have been requested
        if (rd_valid && (state_reg != DRAIN)) begin
            err_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = FILL;
                    add_cnt_next   = '0;
                    rm_cnt_next    = '0;
                    rd_cnt_next    = '0;
                    last_key_next  = '0;
                    round_cnt_next = '0;
                end
            end
            FILL: begin
                add = !pq_full && (add_cnt_reg < N_FILL_C);
                if (add && cmd_ready) begin
                    lfsr_adv     = 1'b1;
                    add_cnt_next = add_cnt_reg + CW'(1);
                end
                if ((add_cnt_reg == N_FILL_C) || (pq_full && !(add && cmd_ready))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                remove = !pq_empty && (rm_cnt_reg < add_cnt_reg);
                if (remove && cmd_ready) begin
                    rm_cnt_next = rm_cnt_reg + CW'(1);
                end
                // Queue claims empty while it should still hold entries
                if (pq_empty && (rm_cnt_reg < add_cnt_reg)) begin
                    err_next = 1'b1;
                end
                if (rd_valid) begin
                    if (rd_cnt_reg == rm_cnt_reg) begin
                        err_next = 1'b1;
                    end else begin
                        if (rd_key < last_key_reg) begin
                            err_next = 1'b1;
                        end
                        last_key_next = rd_key;
                        rd_cnt_next   = rd_cnt_reg + CW'(1);
                    end
                end
                // Round ends on the edge that consumes the last result
                if (rd_cnt_next == add_cnt_reg) begin
                    round_cnt_next = round_cnt_reg + RW'(1);
                    add_cnt_next   = '0;
                    rm_cnt_next    = '0;
                    rd_cnt_next    = '0;
                    last_key_next  = '0;
                    state_next     = (round_cnt_reg == LAST_ROUND) ? DONE : FILL;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            add_cnt_reg   <= '0;
            rm_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            last_key_reg  <= '0;
            round_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            add_cnt_reg   <= add_cnt_next;
            rm_cnt_reg    <= rm_cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            last_key_reg  <= last_key_next;
            round_cnt_reg <= round_cnt_next;
            err_reg       <= err_next;
        end
    end

    assign err       = err_reg;
    assign round_cnt = round_cnt_reg;

endmodule

// File: tb/tb_pq_cmd_gen.sv
// Bench for pq_cmd_gen: a behavioural priority queue answers the commands,
// a scoreboard holds the expected add sequence, and a monitor checks every
// accepted add, request stability and the ordering error flag.
module tb_pq_cmd_gen;

    localparam int KW     = 8;
    localparam int VW     = 8;
    localparam int N_FILL = 16;
    localparam int ROUNDS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       pq_full = 1'b0;
    logic       pq_empty = 1'b1;
    logic       rd_valid = 1'b0;
    logic [7:0] rd_key = 8'h00;
    logic       add, remove, done, err;
    logic [7:0] data1, data2;
    logic [2:0] round_cnt;

    pq_cmd_gen #(
        .KW(KW), .VW(VW), .SEED(8'hA5), .N_FILL(N_FILL), .ROUNDS(ROUNDS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_ready(cmd_ready),
        .pq_full(pq_full), .pq_empty(pq_empty), .rd_valid(rd_valid),
        .rd_key(rd_key), .add(add), .remove(remove), .data1(data1),
        .data2(data2), .done(done), .err(err), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Bench controls for the queue model
    int depth    = 32;
    int rdy_mode = 0;      // 0: always ready, 1: random, 2: never ready
    bit bad_mode = 1'b0;   // first two results of a run become 8'h10, 8'h0F

    logic [15:0] exp_q[$];
    int n_add_acc = 0, n_rm_acc = 0, n_rd_acc = 0;
    bit bad_0f_present = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural priority queue ----------------
    logic [7:0] store[$];
    logic [7:0] pend_key[$];
    int         pend_due[$];
    int         cyc = 0;
    int         bad_idx = 0;
    int         mi;
    bit         s_add, s_rm, s_rdv, s_rst;
    logic [7:0] s_d1;

    initial begin : pq_model
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_add = add && cmd_ready;
            s_rm  = remove && cmd_ready;
            s_rdv = rd_valid;
            s_d1  = data1;
            @(posedge clk);
            #1;
            cyc++;
            if (s_rst) begin
                store.delete();
                pend_key.delete();
                pend_due.delete();
                bad_idx = 0;
            end else begin
                if (s_rdv && pend_key.size() > 0) begin
                    void'(pend_key.pop_front());
                    void'(pend_due.pop_front());
                    bad_idx++;
                end
                if (s_add) store.push_back(s_d1);
                if (s_rm && store.size() > 0) begin
                    mi = 0;
                    for (int i = 1; i < store.size(); i++)
                        if (store[i] < store[mi]) mi = i;
                    pend_key.push_back(store[mi]);
                    pend_due.push_back(cyc + int'($urandom_range(0, 3)));
                    store.delete(mi);
                end
            end
            pq_full  = (store.size() >= depth);
            pq_empty = (store.size() == 0);
            rd_valid = (pend_key.size() > 0) && (pend_due[0] <= cyc);
            if (!rd_valid)                        rd_key = 8'h00;
            else if (bad_mode && bad_idx == 0)    rd_key = 8'h10;
            else if (bad_mode && bad_idx == 1)    rd_key = 8'h0F;
            else                                  rd_key = pend_key[0];
            bad_0f_present = rd_valid && bad_mode && (bad_idx == 1);
            if (rdy_mode == 0)      cmd_ready = 1'b1;
            else if (rdy_mode == 1) cmd_ready = ($urandom_range(0, 3) != 0);
            else                    cmd_ready = 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          prev_add_hold = 1'b0, prev_rm_hold = 1'b0, chk_err = 1'b0;
    logic [7:0]  prev_d1, prev_d2;
    logic [15:0] exp_item;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_add_hold = 1'b0;
                prev_rm_hold  = 1'b0;
                chk_err       = 1'b0;
                continue;
            end
            check("add_remove_exclusive", 32'(add && remove), 32'd0);
            if (prev_add_hold && !pq_full)
                check("add_held_stable", {15'd0, add, data1, data2}, {15'd0, 1'b1, prev_d1, prev_d2});
            if (prev_rm_hold && !pq_empty)
                check("remove_held", 32'(remove), 32'd1);
            if (chk_err) begin
                check("err_after_0F", 32'(err), 32'd1);
                chk_err = 1'b0;
            end
            if (bad_0f_present && rd_valid) begin
                check("err_before_0F", 32'(err), 32'd0);
                chk_err = 1'b1;
            end
            if (add && cmd_ready) begin
                n_add_acc++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL add_data: got add %02h/%02h, expected no add", data1, data2);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({data1, data2} !== exp_item) begin
                        n_bad++;
                        $display("FAIL add_data: got %02h/%02h, expected %02h/%02h",
                                 data1, data2, exp_item[15:8], exp_item[7:0]);
                    end
                end
            end
            if (remove && cmd_ready) n_rm_acc++;
            if (rd_valid)            n_rd_acc++;
            prev_add_hold = add && !cmd_ready;
            prev_rm_hold  = remove && !cmd_ready;
            prev_d1       = data1;
            prev_d2       = data2;
        end
    end

    // ---------------- reference and helpers ----------------
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    // Expected adds of a whole run from a fresh reset
    task automatic push_run(input int per_round);
        logic [7:0] k;
        k = 8'hA5;
        for (int r = 0; r < ROUNDS; r++) begin
            for (int i = 0; i < per_round; i++) begin
                exp_q.push_back({k, 8'(i)});
                k = lfsr_next(k);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_counts();
        exp_q.delete();
        n_add_acc = 0;
        n_rm_acc  = 0;
        n_rd_acc  = 0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick(2);
        clear_counts();
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 5000) begin
            tick(1);
            t++;
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic run_checks(input int n_exp, input bit exp_err);
        check("round_cnt_at_done", 32'(round_cnt), 32'(ROUNDS));
        check("err_at_done", 32'(err), 32'(exp_err));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("adds_accepted", 32'(n_add_acc), 32'(n_exp));
        check("removes_accepted", 32'(n_rm_acc), 32'(n_exp));
        check("results_consumed", 32'(n_rd_acc), 32'(n_exp));
        start = 1'b0;
        tick(1);
        check("idle_after_start_low", 32'(done), 32'd0);
        tick(1);
        check("idle_no_add", 32'(add), 32'd0);
        check("err_sticky_in_idle", 32'(err), 32'(exp_err));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_add"}, 32'(add), 32'd0);
        check({tag, "_remove"}, 32'(remove), 32'd0);
        check({tag, "_data1"}, 32'(data1), 32'hA5);
        check({tag, "_data2"}, 32'(data2), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_round_cnt"}, 32'(round_cnt), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int         t;
    int         n_before;
    logic [7:0] held_d1;

    initial begin : main
        // Reset state
        do_reset();
        check_reset_values("reset");

        // Ideal queue, always ready: first keys A5 then EA
        depth    = 32;
        rdy_mode = 0;
        push_run(N_FILL);
        start = 1'b1;
        check("no_add_before_fill", 32'(add), 32'd0);
        tick(1);
        check("first_add", {31'd0, add}, 32'd1);
        check("first_data1", 32'(data1), 32'hA5);
        check("first_data2", 32'(data2), 32'd0);
        tick(1);
        check("second_data1", 32'(data1), 32'hEA);
        check("second_data2", 32'(data2), 32'd1);
        wait_done();
        run_checks(ROUNDS * N_FILL, 1'b0);

        // Depth-8 queue with random ready: 8 adds per round
        do_reset();
        depth    = 8;
        rdy_mode = 1;
        push_run(8);
        start = 1'b1;
        wait_done();
        run_checks(ROUNDS * 8, 1'b0);

        // Ready held low for 5 cycles mid-fill
        do_reset();
        depth    = 32;
        rdy_mode = 0;
        push_run(N_FILL);
        start = 1'b1;
        t = 0;
        while (n_add_acc < 3 && t < 100) begin
            tick(1);
            t++;
        end
        rdy_mode = 2;
        tick(1);
        held_d1  = data1;
        n_before = n_add_acc;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("hold_add", 32'(add), 32'd1);
            check("hold_data1", 32'(data1), 32'(held_d1));
        end
        check("no_accept_while_not_ready", 32'(n_add_acc), 32'(n_before));
        rdy_mode = 0;
        wait_done();
        run_checks(ROUNDS * N_FILL, 1'b0);

        // Out-of-order results 8'h10 then 8'h0F
        do_reset();
        depth    = 32;
        rdy_mode = 1;
        bad_mode = 1'b1;
        push_run(N_FILL);
        start = 1'b1;
        wait_done();
        run_checks(ROUNDS * N_FILL, 1'b1);
        bad_mode = 1'b0;

        // Reset in the middle of DRAIN, then restart
        do_reset();
        depth    = 32;
        rdy_mode = 0;
        push_run(N_FILL);
        start = 1'b1;
        t = 0;
        while (!remove && t < 200) begin
            tick(1);
            t++;
        end
        check("reached_drain", 32'(remove), 32'd1);
        tick(2);
        rst   = 1'b1;
        start = 1'b0;
        tick(1);
        check_reset_values("mid_drain_reset");
        clear_counts();
        rst = 1'b0;
        tick(1);
        push_run(N_FILL);
        start = 1'b1;
        tick(1);
        check("restart_data1", 32'(data1), 32'hA5);
        wait_done();
        run_checks(ROUNDS * N_FILL, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pq_cmd_gen.md
# pq_cmd_gen

Upstream stimulus and self-check stage for the `high_level` priority-queue core. It drives the `data1`/`data2` ports and issues add/remove commands. In each round it fills the queue with pseudo-random keys, then drains it. It checks that the removed keys come out in non-decreasing order (min-first) and that the remove count matches the add count. It replaces the hand-written bench stimulus and is also synthesised on the board so that the `start` switch runs a self-checking demo.

## Interface
Parameters:
- `KW`, 8: key width; drives `data1`.
- `VW`, 8: payload width; drives `data2`.
- `SEED`, 8'hA5: LFSR reload value. A value of 0 is replaced by 1.
- `N_FILL`, 16: maximum adds per round.
- `ROUNDS`, 4: fill/drain rounds per run.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  level; a run begins when it is high in IDLE.
- `cmd_ready`  in  1  PQ accepts the presented add/remove this cycle.
- `pq_full`  in  1  PQ full flag.
- `pq_empty`  in  1  PQ empty flag.
- `rd_valid`  in  1  a removed key is presented.
- `rd_key`  in  KW  removed key.
- `add`  out  1  add request.
- `remove`  out  1  remove request.
- `data1`  out  KW  key for add.
- `data2`  out  VW  payload for add.
- `done`  out  1  run complete.
- `err`  out  1  sticky check failure.
- `round_cnt`  out  $clog2(ROUNDS+1)  completed rounds.

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE → FILL when `start`=1.
  - Clears `add_cnt`, `rd_cnt`, `round_cnt` and `last_key`.
  - `err` is not cleared.
- FILL:
  - `add` = !`pq_full` && `add_cnt` < N_FILL.
  - `data1` = LFSR state; `data2` = `add_cnt`[VW-1:0].
  - On `add`&&`cmd_ready`: LFSR advances and `add_cnt`++.
  - Exit to DRAIN when `add_cnt`==N_FILL, or when `pq_full`=1 with no accepted add that cycle.
- DRAIN:
  - `remove` = !`pq_empty` && `rm_cnt` < `add_cnt`.
  - On acceptance: `rm_cnt`++.
  - On `rd_valid`: if `rd_key` < `last_key`, set `err`. Then `last_key` ← `rd_key` and `rd_cnt`++.
  - Exit when `rd_cnt`==`add_cnt`: `round_cnt`++, and `add_cnt`, `rm_cnt`, `rd_cnt`, `last_key` are cleared.
  - Next state is DONE if `round_cnt`+1==ROUNDS, otherwise FILL.
- DONE: `done`=1. → IDLE when `start`=0.
- LFSR: 8-bit Galois, right shift, XOR mask 8'hB8 when the shifted-out bit is 1. It advances only on an accepted add. It is not reloaded between rounds, only on reset.
- Error conditions, all sticky until `rst`:
  - `pq_empty`=1 in DRAIN with `rm_cnt` < `add_cnt`.
  - `rd_valid` in any state other than DRAIN.
  - `rd_valid` when `rd_cnt`==`rm_cnt`, i.e. an unrequested result.
- `add` and `remove` are never asserted together.
- A request stays high with stable `data1`/`data2` until `cmd_ready`, unless `pq_full`/`pq_empty` rises. In that case it drops in the same cycle.

## Timing
- Reset values: `add`=0, `remove`=0, `data1`=SEED, `data2`=0, `done`=0, `err`=0, `round_cnt`=0, state IDLE.
- `rst` mid-run returns everything to reset values at the next edge and reloads the LFSR.
- `start` is sampled at a `clk` edge. `add` rises the cycle after the IDLE→FILL edge.
- `add`/`remove` are combinational from registered state, counters and the `pq_full`/`pq_empty` inputs.
- `data1`/`data2` are combinational from registers.
- Acceptance is `add`&&`cmd_ready` (or `remove`&&`cmd_ready`) at the rising edge. With `cmd_ready` tied high, throughput is one command per cycle.
- `rd_valid` latency after remove acceptance is arbitrary but results are in order. `rd_valid` in the same cycle as an acceptance is legal.
- The DRAIN→FILL/DONE transition occurs on the edge that consumes the last `rd_valid`. The first add of the next round appears the following cycle.

## Structure
- Package `pq_pkg` holds:
  - `KW`/`VW` defaults;
  - the state enum `gen_state_t` (IDLE, FILL, DRAIN, DONE);
  - the LFSR mask constant `LFSR_MASK` = 8'hB8.
- Sub-module `pq_lfsr` contains the seeded Galois LFSR with advance enable and synchronous reload.
- The FSM, counters and checker stay in `pq_cmd_gen`.

## Test plan
- Reset, then `start`=1 with `cmd_ready`=1: first `add` has `data1`=8'hA5 and `data2`=0; second has `data1`=8'hEA and `data2`=1.
- Model PQ of depth 8, N_FILL=16: `pq_full` after 8 adds → exactly 8 removes follow; `rd_cnt` ends at 8; `err`=0.
- Ideal sorted model, ROUNDS=4: `done` rises after 4 rounds and `round_cnt`=4. With `start`=0, the block is back in IDLE one cycle later.
- Model returns keys 8'h10 then 8'h0F → `err`=1 on the edge consuming 8'h0F and stays high through DONE.
- `cmd_ready`=0 for 5 cycles during FILL → `add` and `data1` are held constant and the LFSR does not advance.
- `rst`=1 mid-DRAIN → next cycle all outputs are at reset values. Restarting reproduces the first key 8'hA5.
